// File: rtl/wb_stage.sv
// MEM/WB pipeline stage: load extraction, write-back source select, register
// file write port, retired-instruction counter and faulting-load flag.
module wb_stage #(
   parameter int INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_valid,
   input  logic [4:0]           mem_rd_addr,
   input  logic                 mem_rd_wen,
   input  logic [1:0]           mem_wb_sel,
   input  logic [31:0]          mem_alu_result,
   input  logic [31:0]          mem_pc_plus4,
   input  logic [31:0]          mem_load_data,
   input  logic [2:0]           mem_funct3,
   input  logic                 stall,
   input  logic                 flush,
   output logic [4:0]           rd_addr,
   output logic [31:0]          rd_data,
   output logic                 rd_wen,
   output logic                 wb_valid,
   output logic                 load_fault,
   output logic [INSTRET_W-1:0] instret
);

   localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

   logic [1:0]  lo;
   logic        is_load;
   logic [31:0] shifted;
   logic [31:0] load_val;
   logic        raw_fault;
   logic        fault;
   logic [31:0] wr_data;
   logic        cap_wen;
   logic        retire;

   always_comb begin
      lo        = mem_alu_result[1:0];
      is_load   = (mem_wb_sel == 2'b01);
      // Aligned byte/half lands in the low bits after shifting by 8*lo.
      shifted   = mem_load_data >> {lo, 3'b000};
      load_val  = '0;
      raw_fault = 1'b0;
      case (mem_funct3)
         3'b000: load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b100: load_val = {24'b0, shifted[7:0]};
         3'b001: begin
            load_val  = {{16{shifted[15]}}, shifted[15:0]};
            raw_fault = lo[0];
         end
         3'b101: begin
            load_val  = {16'b0, shifted[15:0]};
            raw_fault = lo[0];
         end
         3'b010: begin
            load_val  = mem_load_data;
            raw_fault = (lo != 2'b00);
         end
         default: raw_fault = 1'b1;
      endcase

      fault = raw_fault & is_load & mem_valid;

      case (mem_wb_sel)
         2'b01:   wr_data = load_val;
         2'b10:   wr_data = mem_pc_plus4;
         default: wr_data = mem_alu_result;
      endcase
      if (fault) begin
         wr_data = '0;
      end

      cap_wen = mem_valid & mem_rd_wen & (mem_rd_addr != 5'd0) & ~fault;
      retire  = mem_valid & ~fault;
   end

   // Edge priority is flush > stall > capture; a stall holds the write port
   // but clears load_fault so a fault is reported exactly once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr    <= '0;
         rd_data    <= '0;
         rd_wen     <= 1'b0;
         wb_valid   <= 1'b0;
         load_fault <= 1'b0;
         instret    <= '0;
      end else if (flush) begin
         rd_addr    <= '0;
         rd_data    <= '0;
         rd_wen     <= 1'b0;
         wb_valid   <= 1'b0;
         load_fault <= 1'b0;
      end else if (stall) begin
         load_fault <= 1'b0;
      end else begin
         rd_addr    <= mem_valid ? mem_rd_addr : 5'd0;
         rd_data    <= mem_valid ? wr_data : 32'd0;
         rd_wen     <= cap_wen;
         wb_valid   <= mem_valid;
         load_fault <= fault;
         if (retire) begin
            instret <= instret + INSTRET_ONE;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboarded bench for wb_stage: driver pushes expectations from a
// rule-level model, a negedge monitor pops and compares both DUT widths.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid;
   logic [4:0]  mem_rd_addr;
   logic        mem_rd_wen;
   logic [1:0]  mem_wb_sel;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_pc_plus4;
   logic [31:0] mem_load_data;
   logic [2:0]  mem_funct3;
   logic        stall;
   logic        flush;

   logic [4:0]  rd_addr,    rd_addr_n4;
   logic [31:0] rd_data,    rd_data_n4;
   logic        rd_wen,     rd_wen_n4;
   logic        wb_valid,   wb_valid_n4;
   logic        load_fault, load_fault_n4;
   logic [63:0] instret;
   logic [3:0]  instret_n4;

   wb_stage #(.INSTRET_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_rd_addr(mem_rd_addr),
      .mem_rd_wen(mem_rd_wen), .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
      .mem_pc_plus4(mem_pc_plus4), .mem_load_data(mem_load_data), .mem_funct3(mem_funct3),
      .stall(stall), .flush(flush), .rd_addr(rd_addr), .rd_data(rd_data), .rd_wen(rd_wen),
      .wb_valid(wb_valid), .load_fault(load_fault), .instret(instret)
   );

   wb_stage #(.INSTRET_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_rd_addr(mem_rd_addr),
      .mem_rd_wen(mem_rd_wen), .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
      .mem_pc_plus4(mem_pc_plus4), .mem_load_data(mem_load_data), .mem_funct3(mem_funct3),
      .stall(stall), .flush(flush), .rd_addr(rd_addr_n4), .rd_data(rd_data_n4), .rd_wen(rd_wen_n4),
      .wb_valid(wb_valid_n4), .load_fault(load_fault_n4), .instret(instret_n4)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   typedef struct {
      int          tgt;
      logic        valid;
      logic        wen;
      logic        fault;
      logic        chk_data;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [63:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference state: what the write port should currently show
   logic        m_valid, m_wen, m_fault, m_chkd;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic [63:0] m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_wen = 0; m_fault = 0; m_chkd = 0;
      m_addr = 0; m_data = 0; m_cnt = 0;
      exp_q.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".rd_addr"},    64'(rd_addr), 64'd0);
      chk({tag, ".rd_data"},    64'(rd_data), 64'd0);
      chk({tag, ".rd_wen"},     64'(rd_wen), 64'd0);
      chk({tag, ".wb_valid"},   64'(wb_valid), 64'd0);
      chk({tag, ".load_fault"}, 64'(load_fault), 64'd0);
      chk({tag, ".instret"},    instret, 64'd0);
      chk({tag, ".instret4"},   64'(instret_n4), 64'd0);
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n === 1'b1 && exp_q.size() > 0) begin
         if (exp_q[0].tgt < cyc) begin
            mon_e = exp_q.pop_front();
            errors++;
            $display("FAIL stale_expectation tgt=%0d actual_cyc=%0d", mon_e.tgt, cyc);
         end else if (exp_q[0].tgt == cyc) begin
            mon_e = exp_q.pop_front();
            chk("wb_valid",   64'(wb_valid), 64'(mon_e.valid));
            chk("rd_wen",     64'(rd_wen), 64'(mon_e.wen));
            chk("load_fault", 64'(load_fault), 64'(mon_e.fault));
            chk("instret",    instret, mon_e.cnt);
            chk("instret_w4", 64'(instret_n4), {60'd0, mon_e.cnt[3:0]});
            chk("w4_wen",     64'(rd_wen_n4), 64'(mon_e.wen));
            if (mon_e.valid) chk("rd_addr", 64'(rd_addr), 64'(mon_e.addr));
            if (mon_e.chk_data) chk("rd_data", 64'(rd_data), 64'(mon_e.data));
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic wen, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic [31:0] ld,
                        input logic [2:0] f3, input logic st, input logic fl);
      exp_t        e;
      logic [1:0]  lo;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] val;
      logic        flt;
      mem_valid = v; mem_rd_wen = wen; mem_rd_addr = rd; mem_wb_sel = sel;
      mem_alu_result = alu; mem_pc_plus4 = pc4; mem_load_data = ld;
      mem_funct3 = f3; stall = st; flush = fl;

      lo  = alu[1:0];
      b   = ld[8*lo +: 8];
      h   = ld[16*lo[1] +: 16];
      val = 32'd0;
      flt = 1'b0;
      case (f3)
         3'd0: val = 32'($signed(b));
         3'd4: val = 32'(b);
         3'd1: begin val = 32'($signed(h)); flt = lo[0]; end
         3'd5: begin val = 32'(h); flt = lo[0]; end
         3'd2: begin val = ld; flt = (lo != 0); end
         default: flt = 1'b1;
      endcase
      flt = flt && v && (sel == 2'b01);

      if (fl) begin
         m_valid = 0; m_wen = 0; m_fault = 0; m_chkd = 0;
      end else if (st) begin
         m_fault = 0;
      end else begin
         m_valid = v;
         m_fault = flt;
         m_wen   = v && wen && (rd != 0) && !flt;
         m_addr  = rd;
         if (flt)              m_data = 32'd0;
         else if (sel == 2'b01) m_data = val;
         else if (sel == 2'b10) m_data = pc4;
         else                  m_data = alu;
         m_chkd = m_wen || flt;
         if (v && !flt) m_cnt = m_cnt + 64'd1;
      end

      e.tgt = cyc + 1; e.valid = m_valid; e.wen = m_wen; e.fault = m_fault;
      e.chk_data = m_chkd; e.addr = m_addr; e.data = m_data; e.cnt = m_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic alu_op(input logic [4:0] rd, input logic [31:0] v);
      drive(1, 1, rd, 2'b00, v, 32'h0, 32'h0, 3'd0, 0, 0);
   endtask

   task automatic load_op(input logic [2:0] f3, input logic [1:0] lo);
      drive(1, 1, 5'd5, 2'b01, {30'h40, lo}, 32'h0, 32'h80FF_1234, f3, 0, 0);
   endtask

   task automatic idle_op();
      drive(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'd0, 0, 0);
   endtask

   // ---------------- stimulus ----------------
   logic        r_v, r_wen, r_st, r_fl;
   logic [4:0]  r_rd;
   logic [1:0]  r_sel;
   logic [2:0]  r_f3;

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      mem_valid = 0; mem_rd_wen = 0; mem_rd_addr = 0; mem_wb_sel = 0;
      mem_alu_result = 0; mem_pc_plus4 = 0; mem_load_data = 0;
      mem_funct3 = 0; stall = 0; flush = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;

      // counter wrap on the 4-bit instance: 0xF after 15, 0x0 after 16, 0x1 after 17
      for (int i = 0; i < 17; i++) alu_op(5'(i % 31 + 1), 32'(i * 3));

      // load extraction from 0x80FF_1234
      load_op(3'b000, 2'd3);
      load_op(3'b100, 2'd3);
      load_op(3'b001, 2'd2);
      load_op(3'b101, 2'd0);
      load_op(3'b010, 2'd0);

      // faulting loads, each followed by a normal op so the pulse must drop
      load_op(3'b010, 2'd2);
      alu_op(5'd2, 32'h11);
      load_op(3'b011, 2'd0);
      load_op(3'b001, 2'd1);
      alu_op(5'd2, 32'h22);

      // x0 destination and link select
      alu_op(5'd0, 32'h1234);
      drive(1, 1, 5'd1, 2'b10, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0, 3'd0, 0, 0);

      // stall three cycles with a live instruction waiting upstream
      alu_op(5'd7, 32'hABCD);
      repeat (3) drive(1, 1, 5'd9, 2'b00, 32'h999, 32'h0, 32'h0, 3'd0, 1, 0);
      alu_op(5'd9, 32'h999);

      // fault then stall: the pulse is not repeated
      load_op(3'b111, 2'd0);
      drive(1, 1, 5'd3, 2'b00, 32'h3, 32'h0, 32'h0, 3'd0, 1, 0);

      // flush wins over stall, then a bubble
      drive(1, 1, 5'd4, 2'b00, 32'h44, 32'h0, 32'h0, 3'd0, 1, 1);
      idle_op();
      alu_op(5'd6, 32'h66);

      // asynchronous reset between edges while rd_wen is high
      alu_op(5'd3, 32'h55);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_zero("rst_mid");
      @(posedge clk);
      #1;
      check_zero("rst_hold");
      rst_n = 1'b1;
      alu_op(5'd4, 32'h77);
      idle_op();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         r_v   = ($urandom_range(9, 0) != 0);
         r_wen = ($urandom_range(4, 0) != 0);
         r_rd  = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
         r_sel = 2'($urandom_range(3, 0));
         r_f3  = 3'($urandom_range(7, 0));
         r_st  = ($urandom_range(9, 0) == 0);
         r_fl  = ($urandom_range(19, 0) == 0);
         drive(r_v, r_wen, r_rd, r_sel, $urandom, $urandom, $urandom, r_f3, r_st, r_fl);
      end
      idle_op();

      repeat (3) @(posedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline stage of the five-stage RV32I core.
- Captures one instruction per cycle from the memory stage and performs load byte/half extraction with sign or zero extension.
- Selects the write-back source and drives the register file write port (rd_addr, rd_data, rd_wen).
- Keeps a retired-instruction counter and flags faulting loads. Sits directly upstream of the register file.

Parameters:
- INSTRET_W, 64, width of the retired-instruction counter. Wraps modulo 2^INSTRET_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_rd_addr  in  5  destination register.
- mem_rd_wen  in  1  instruction writes rd.
- mem_wb_sel  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- mem_alu_result  in  32  ALU result. For loads this is the effective address.
- mem_pc_plus4  in  32  link value.
- mem_load_data  in  32  raw aligned word from data memory, valid in the same cycle.
- mem_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- stall  in  1  hold the WB register.
- flush  in  1  replace the WB contents with a bubble.
- rd_addr  out  5  register file write address.
- rd_data  out  32  register file write data.
- rd_wen  out  1  register file write enable.
- wb_valid  out  1  WB holds a real instruction.
- load_fault  out  1  one-cycle pulse: the captured load was misaligned or had a reserved funct3.
- instret  out  INSTRET_W  count of retired instructions.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, including instret. Takes effect immediately mid-operation; the in-flight instruction is dropped. First capture happens on the first rising edge after rst_n goes high.
- Latency: 1 cycle. MEM inputs at edge N appear on the outputs after edge N. Extraction and selection are combinational ahead of the register, so all outputs are registered.
- Load extraction, with lo = mem_alu_result[1:0]:
  - LB/LBU: byte lo (bits 8*lo+7 : 8*lo), sign- or zero-extended.
  - LH/LHU: half at lo[1], sign- or zero-extended.
  - LW: whole word.
- Fault conditions, when mem_wb_sel = 01 only:
  - LH/LHU with lo[0] = 1;
  - LW with lo != 0;
  - funct3 in {011, 110, 111}.
  - On a fault: captured rd_wen = 0, rd_data = 0, load_fault = 1 for exactly that cycle. wb_valid is still 1; the instruction is not counted.
- Captured rd_wen = mem_valid & mem_rd_wen & (mem_rd_addr != 0) & no fault. A write to x0 never asserts rd_wen.
- Priority at each edge: flush > stall > capture.
  - flush: wb_valid = 0, rd_wen = 0, load_fault = 0; rd_addr and rd_data are don't-care (implement as 0). Applies even if stall = 1.
  - stall (no flush): rd_addr, rd_data, rd_wen and wb_valid hold. load_fault drops to 0, so the pulse is never repeated. instret does not change. A held rd_wen rewrites the same value, which is harmless.
  - capture: load all fields from MEM.
- instret increments by 1 on each capture edge where mem_valid = 1 and there is no fault. x0 destinations and non-writing instructions (stores, branches) still count. Wraps from all-ones to 0 with no flag.
- A bubble (mem_valid = 0) captures wb_valid = 0 and rd_wen = 0, and instret is unchanged.

Test Plan:
- Reset mid-stream: assert rst_n low between edges while rd_wen = 1 -> all outputs 0 immediately; instret 0; first post-reset capture appears one edge after release.
- Load extraction, mem_load_data = 0x80FF_1234:
  - LB, lo = 3 -> rd_data 0xFFFF_FF80.
  - LBU, lo = 3 -> 0x0000_0080.
  - LH, lo = 2 -> 0xFFFF_80FF.
  - LHU, lo = 0 -> 0x0000_1234.
  - LW, lo = 0 -> 0x80FF_1234.
  - Each with rd_wen = 1 and rd_addr = 5.
- Faults:
  - LW with lo = 2 -> rd_wen 0, load_fault 1 for one cycle, instret unchanged.
  - funct3 = 011 -> same response.
  - LH with lo = 1 -> same response.
- x0 and select: ALU op to rd = 0, result 0x1234 -> rd_wen 0, instret +1. JAL-style wb_sel = 10, pc_plus4 = 0x0000_0104, rd = 1 -> rd_data 0x104, rd_wen 1.
- Stall/flush:
  - Stall 3 cycles after capturing rd = 7 -> outputs held, instret +1 total.
  - flush = stall = 1 -> wb_valid 0, rd_wen 0.
  - Bubble input -> rd_wen 0, instret unchanged.
- Counter wrap with INSTRET_W = 4: 17 valid non-faulting instructions -> instret 0xF after 15, 0x0 after 16, 0x1 after 17.
